// File: rtl/exc_ctrl_pkg.sv
// Shared exception codes, CP0 register addresses and FSM state type for the
// MEM-stage exception controller and CP0.
package exc_ctrl_pkg;

  localparam logic [31:0] EXC_INT  = 32'h0000_0001;
  localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
  localparam logic [31:0] EXC_ADES = 32'h0000_0005;
  localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
  localparam logic [31:0] EXC_BP   = 32'h0000_0009;
  localparam logic [31:0] EXC_RI   = 32'h0000_000a;
  localparam logic [31:0] EXC_OV   = 32'h0000_000c;
  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  typedef enum logic {
    S_IDLE,
    S_FLUSH
  } exc_state_t;

endpackage

// File: rtl/exc_ctrl_if.sv
// Bus between the MEM stage / CP0 side and the exception controller.
interface exc_if;
  logic [5:0]  hw_int_i;
  logic [5:0]  int_o;
  logic        mem_valid_i;
  logic [31:0] mem_pc_i;
  logic        mem_in_delayslot_i;
  logic [31:0] mem_data_addr_i;
  logic        exc_if_adel_i;
  logic        exc_ri_i;
  logic        exc_ov_i;
  logic        exc_sys_i;
  logic        exc_bp_i;
  logic        exc_adel_i;
  logic        exc_ades_i;
  logic        exc_eret_i;
  logic [31:0] status_i;
  logic [31:0] cause_i;
  logic [31:0] epc_i;
  logic        wb_cp0_we_i;
  logic [4:0]  wb_cp0_waddr_i;
  logic [31:0] wb_cp0_wdata_i;
  logic [31:0] excepttype_o;
  logic [31:0] current_inst_addr_o;
  logic        is_in_delayslot_o;
  logic [31:0] bad_addr_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        busy_o;

  modport master (
    output hw_int_i, mem_valid_i, mem_pc_i, mem_in_delayslot_i, mem_data_addr_i,
           exc_if_adel_i, exc_ri_i, exc_ov_i, exc_sys_i, exc_bp_i, exc_adel_i,
           exc_ades_i, exc_eret_i, status_i, cause_i, epc_i,
           wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_wdata_i,
    input  int_o, excepttype_o, current_inst_addr_o, is_in_delayslot_o,
           bad_addr_o, flush_o, new_pc_o, busy_o
  );

  modport slave (
    input  hw_int_i, mem_valid_i, mem_pc_i, mem_in_delayslot_i, mem_data_addr_i,
           exc_if_adel_i, exc_ri_i, exc_ov_i, exc_sys_i, exc_bp_i, exc_adel_i,
           exc_ades_i, exc_eret_i, status_i, cause_i, epc_i,
           wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_wdata_i,
    output int_o, excepttype_o, current_inst_addr_o, is_in_delayslot_o,
           bad_addr_o, flush_o, new_pc_o, busy_o
  );
endinterface

// File: rtl/exc_ctrl_int_sync.sv
// Two-flop synchroniser with asynchronous reset for external interrupt lines.
module int_sync #(
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;

  // First flop may go metastable; second flop presents the settled value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/exc_ctrl.sv
// MEM-stage exception controller: qualifies interrupts, prioritises exception
// flags, reports one event per instruction to CP0 and drives flush/redirect.
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input logic   clk,
  input logic   rst,
  exc_if.slave  bus
);

  exc_state_t  state;
  logic [2:0]  cnt;
  logic [5:0]  int_sync_q;
  logic        int_pend;
  logic        hit;
  logic        is_eret;
  logic [31:0] code;
  logic [31:0] bad;
  logic [31:0] epc_eff;

  logic [31:0] excepttype_r;
  logic [31:0] inst_addr_r;
  logic        delayslot_r;
  logic [31:0] bad_addr_r;
  logic        flush_r;
  logic [31:0] new_pc_r;

  logic        unused_bits;
  assign unused_bits = ^{bus.status_i[31:16], bus.status_i[7:2],
                         bus.cause_i[31:16], bus.cause_i[7:0]};

  int_sync #(.WIDTH(6)) u_int_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.hw_int_i),
    .q   (int_sync_q)
  );
  assign bus.int_o = int_sync_q;

  assign int_pend = bus.status_i[0] & ~bus.status_i[1] & bus.mem_valid_i &
                    (|(bus.cause_i[15:8] & bus.status_i[15:8]));

  // An in-flight CP0 EPC write must win over the stale register value for ERET.
  assign epc_eff = (bus.wb_cp0_we_i && bus.wb_cp0_waddr_i == CP0_EPC) ?
                   bus.wb_cp0_wdata_i : bus.epc_i;

  // Fixed-priority selection of one exception source for the MEM instruction.
  always_comb begin
    hit     = 1'b0;
    is_eret = 1'b0;
    code    = '0;
    bad     = '0;
    if (bus.mem_valid_i) begin
      hit = 1'b1;
      if (int_pend)                    code = EXC_INT;
      else if (bus.exc_if_adel_i) begin code = EXC_ADEL; bad = bus.mem_pc_i; end
      else if (bus.exc_ri_i)           code = EXC_RI;
      else if (bus.exc_ov_i)           code = EXC_OV;
      else if (bus.exc_sys_i)          code = EXC_SYS;
      else if (bus.exc_bp_i)           code = EXC_BP;
      else if (bus.exc_adel_i) begin   code = EXC_ADEL; bad = bus.mem_data_addr_i; end
      else if (bus.exc_ades_i) begin   code = EXC_ADES; bad = bus.mem_data_addr_i; end
      else if (bus.exc_eret_i) begin   code = EXC_ERET; is_eret = 1'b1; end
      else                             hit = 1'b0;
    end
  end

  // Accept an event in IDLE, then hold flush for FLUSH_CYCLES cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      excepttype_r <= '0;
      inst_addr_r  <= '0;
      delayslot_r  <= 1'b0;
      bad_addr_r   <= '0;
      flush_r      <= 1'b0;
      new_pc_r     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          excepttype_r <= '0;
          flush_r      <= 1'b0;
          if (hit) begin
            excepttype_r <= code;
            inst_addr_r  <= bus.mem_pc_i;
            delayslot_r  <= bus.mem_in_delayslot_i;
            bad_addr_r   <= bad;
            flush_r      <= 1'b1;
            new_pc_r     <= is_eret ? epc_eff : EXC_VECTOR;
            cnt          <= 3'(FLUSH_CYCLES - 1);
            // A single-cycle flush never needs the FLUSH state.
            state        <= (FLUSH_CYCLES > 1) ? S_FLUSH : S_IDLE;
          end
        end
        S_FLUSH: begin
          excepttype_r <= '0;
          if (cnt == '0) begin
            flush_r <= 1'b0;
            state   <= S_IDLE;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.excepttype_o        = excepttype_r;
  assign bus.current_inst_addr_o = inst_addr_r;
  assign bus.is_in_delayslot_o   = delayslot_r;
  assign bus.bad_addr_o          = bad_addr_r;
  assign bus.flush_o             = flush_r;
  assign bus.new_pc_o            = new_pc_r;
  assign bus.busy_o              = (state != S_IDLE);

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- MEM-stage exception controller that sits directly upstream of the CP0 register file.
- Collects raw per-instruction exception flags from the MEM stage and synchronises the external hardware interrupt lines.
- Qualifies interrupts against CP0 Status/Cause, picks one exception per instruction by fixed priority, and drives CP0 for exactly one cycle with the exception code, EPC source, delay-slot flag and bad address.
- Drives the pipeline flush and redirect PC, including ERET through a forwarded EPC.

Parameters:
- EXC_VECTOR, 32'hBFC00380, redirect target for every exception other than ERET.
- FLUSH_CYCLES, 2, number of cycles flush_o stays high per accepted event; legal range 1..7.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- hw_int_i  in  6  raw external interrupt lines, asynchronous to clk.
- int_o  out  6  synchronised interrupt lines; connect to CP0 int_i.
- mem_valid_i  in  1  a valid instruction occupies MEM.
- mem_pc_i  in  32  PC of the MEM instruction.
- mem_in_delayslot_i  in  1  MEM instruction is in a branch delay slot.
- mem_data_addr_i  in  32  data address of the MEM load/store.
- exc_if_adel_i, exc_ri_i, exc_ov_i, exc_sys_i, exc_bp_i, exc_adel_i, exc_ades_i, exc_eret_i  in  1 each  raw flags: fetch AdEL, reserved instruction, overflow, syscall, break, load AdEL, store AdES, ERET.
- status_i  in  32  CP0 Status.
- cause_i  in  32  CP0 Cause.
- epc_i  in  32  CP0 EPC.
- wb_cp0_we_i  in  1  a CP0 write is in flight this cycle.
- wb_cp0_waddr_i  in  5  address of that write.
- wb_cp0_wdata_i  in  32  data of that write.
- excepttype_o  out  32  exception code to CP0.
- current_inst_addr_o  out  32  EPC source to CP0.
- is_in_delayslot_o  out  1  delay-slot flag to CP0.
- bad_addr_o  out  32  bad virtual address to CP0.
- flush_o  out  1  flush IF..MEM.
- new_pc_o  out  32  redirect target, valid while flush_o is high.
- busy_o  out  1  state is not IDLE.

Behaviour:
- Reset values: every output is 0; the synchroniser flops are 0; the state is IDLE.
- Synchroniser: 2-flop synchroniser per bit of hw_int_i; int_o is the second flop, so latency is 2 clk edges.
- Interrupt pending (combinational) when all of the following hold: Status[0] IE=1, Status[1] EXL=0, (cause_i[15:8] & status_i[15:8]) != 0, mem_valid_i=1.
- Detect (combinational, IDLE only, mem_valid_i=1): the highest-priority source sets the code:
  - interrupt = 0x01
  - exc_if_adel = 0x04, bad address = mem_pc_i
  - exc_ri = 0x0a
  - exc_ov = 0x0c
  - exc_sys = 0x08
  - exc_bp = 0x09
  - exc_adel = 0x04, bad address = mem_data_addr_i
  - exc_ades = 0x05, bad address = mem_data_addr_i
  - exc_eret = 0x0e
  - No source means no event.
- EPC forward: effective EPC = wb_cp0_wdata_i when wb_cp0_we_i=1 and wb_cp0_waddr_i=14; otherwise epc_i.
- FSM states are IDLE and FLUSH; a 3-bit counter cnt runs in FLUSH.
- IDLE with an event detected in cycle T, registered at the edge ending T:
  - excepttype_o = code; current_inst_addr_o = mem_pc_i; is_in_delayslot_o = mem_in_delayslot_i; bad_addr_o = selected bad address (0 when the code has none).
  - flush_o = 1; new_pc_o = effective EPC for ERET, else EXC_VECTOR.
  - cnt = FLUSH_CYCLES-1; state goes to FLUSH.
- Result of that event in cycle T+1: CP0 samples the code in T+1; excepttype_o is high only in T+1.
- FLUSH state, each cycle:
  - excepttype_o = 0; flush_o and new_pc_o hold.
  - cnt decrements; when cnt=0 at the edge, flush_o goes to 0 and the state returns to IDLE.
  - All exception flags are ignored, because the instructions carrying them are being flushed.
- FLUSH_CYCLES=1: the FSM goes from IDLE straight back to IDLE and flush_o is high for exactly 1 cycle.
- Back-to-back events: an event present in the first IDLE cycle after FLUSH is accepted normally.
- Status timing: EXL set by CP0 at the end of T+1 is visible in status_i before the FSM returns to IDLE, so nested interrupts are masked.
- Reset asserted mid-FLUSH: all outputs clear immediately, asynchronously, and the state is IDLE.
- An interrupt with mem_valid_i=0 (pipeline bubble) is not taken; it waits for the next valid instruction.

Decomposition:
- Shared package: exception code constants (EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS, EXC_BP, EXC_RI, EXC_OV, EXC_ERET) and CP0 register addresses (EPC=14, STATUS=12, CAUSE=13).
- CP0 uses the same package.
- One sub-module: int_sync, a parameterised-width 2-flop synchroniser with asynchronous reset.

Test Plan:
- Syscall: exc_sys_i=1, mem_pc_i=0xBFC00100, delay slot=0 -> T+1: excepttype_o=0x08, current_inst_addr_o=0xBFC00100, flush_o=1 for 2 cycles, new_pc_o=0xBFC00380.
- Priority and bad address: exc_ov_i, exc_sys_i and exc_ades_i all 1, mem_data_addr_i=0x80000003 -> excepttype_o=0x0c and bad_addr_o=0. Then exc_ades_i alone -> excepttype_o=0x05, bad_addr_o=0x80000003.
- ERET with EPC forwarding: epc_i=0x1000, wb_cp0_we_i=1, waddr=14, wdata=0x2000, exc_eret_i=1 -> excepttype_o=0x0e, new_pc_o=0x2000.
- Interrupt qualification: hw_int_i[2]=1, cause_i[12]=1, status_i=0x00001001 -> int_o[2] rises 2 cycles after hw_int_i, excepttype_o=0x01. Repeat with status_i=0x00001003 (EXL set) -> no event.
- Exception during FLUSH: exc_ri_i=1 in the cycle after acceptance -> ignored, excepttype_o stays 0. exc_ri_i=1 in the first cycle after flush_o falls -> excepttype_o=0x0a.
- Asynchronous reset mid-FLUSH: rst pulsed between edges -> flush_o and busy_o go low before the next edge; next syscall behaves as in scenario 1.
